instr_fetch_ctrl: RTL and testbench

Fetch sequencer between the CPU control path and the synchronous instruction ROM (16-bit word address, 32-bit data, 1-cycle read latency). It owns the fetch PC and issues one ROM read per cycle when space allows. It buffers returned words in a small skid FIFO and presents {pc, instr} to the decoder over a valid/ready handshake. It also handles branch/jump redirects and halt, discarding stale in-flight fetches.

---
 rtl/instr_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: issues one ROM read per cycle against a credit
// limit, buffers returned words in a small skid FIFO, and handles redirect/halt.
module instr_fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [15:0]   fetch_pc_reg, fetch_pc_next;
  logic [15:0]   inflight_pc_reg, inflight_pc_next;
  logic          inflight_reg, inflight_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW:0]   occupancy;
  logic          pop, push, issue;

  logic [15:0] entry_pc_reg    [FIFO_DEPTH];
  logic [31:0] entry_instr_reg [FIFO_DEPTH];

  assign rom_addr  = fetch_pc_reg;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  // A redirect discards the word returning this cycle.
  assign push      = inflight_reg & ~redirect_valid;

  // Buffered plus in-flight entries, less the one leaving this cycle.
  assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, pop};
  assign issue     = ~halt & ~redirect_valid & (occupancy < DEPTH_C);

  // Head is gated so an empty FIFO always presents zeros.
  assign out_pc    = out_valid ? entry_pc_reg[rd_ptr_reg]    : '0;
  assign out_instr = out_valid ? entry_instr_reg[rd_ptr_reg] : '0;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_pc_next = inflight_pc_reg;
    inflight_next    = 1'b0;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    count_next       = count_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (issue) begin
        inflight_pc_next = fetch_pc_reg;
        inflight_next    = 1'b1;
        fetch_pc_next    = fetch_pc_reg + 16'd1;
      end
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_pc_reg <= inflight_pc_next;
      inflight_reg    <= inflight_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
    end
  end

  // Storage needs no reset; stale contents are never visible past count_reg.
  always_ff @(posedge sys_clock) begin
    if (push) begin
      entry_pc_reg[wr_ptr_reg]    <= inflight_pc_reg;
      entry_instr_reg[wr_ptr_reg] <= rom_data;
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: two instances (RESET_PC 0 and FFFE)
// fed by ROM models returning 32'hA000_0000 + address.
module tb_instr_fetch_ctrl;
  logic        sys_clock = 1'b0;
  logic        sys_reset;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        out_ready;

  logic [15:0] rom_addr, out_pc;
  logic [31:0] rom_data, out_instr;
  logic        out_valid;
  logic [15:0] rom_addr_w, out_pc_w;
  logic [31:0] rom_data_w, out_instr_w;
  logic        out_valid_w;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];

  always #5 sys_clock = ~sys_clock;

  instr_fetch_ctrl #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
    .sys_clock(sys_clock), .sys_reset(sys_reset),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch_ctrl #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(2)) dut_wrap (
    .sys_clock(sys_clock), .sys_reset(sys_reset),
    .rom_addr(rom_addr_w), .rom_data(rom_data_w),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_instr(out_instr_w), .out_pc(out_pc_w)
  );

  always @(posedge sys_clock) begin
    rom_data   <= 32'hA000_0000 + {16'h0000, rom_addr};
    rom_data_w <= 32'hA000_0000 + {16'h0000, rom_addr_w};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_stream(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'(start + 16'(i)));
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, score
  // any handshake that edge will complete, then advance to the next falling edge.
  task automatic step(input logic rdy, input logic redir, input logic [15:0] rpc, input logic hlt);
    logic [15:0] exp_pc;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    halt           = hlt;
    if (out_valid && rdy) begin
      check("hs_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        $display("xfer pc=%h instr=%h", out_pc, out_instr);
        check("hs_pc", 64'(out_pc), 64'(exp_pc));
        check("hs_instr", 64'(out_instr), 64'(32'hA000_0000 + 32'(exp_pc)));
      end
    end
    if (redir) exp_q.delete();
    @(negedge sys_clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held_pc, frozen_addr;
    logic [31:0] held_instr;
    int n;
    sys_reset = 1'b1; out_ready = 1'b1; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    repeat (3) @(negedge sys_clock);

    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'h0000);
    check("rst_addr_wrap", 64'(rom_addr_w), 64'hFFFE);

    // Streaming from reset, plus the wrapping instance.
    sys_reset = 1'b0;
    expect_stream(16'h0000, 64);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check("lat_valid_c1", 64'(out_valid), 64'd0);
    check("wrap_addr_c1", 64'(rom_addr_w), 64'hFFFF);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check("lat_valid_c2", 64'(out_valid), 64'd1);
    for (int k = 0; k < 8; k++) begin
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_pc", 64'(out_pc), 64'(k));
      check("stream_ahead", 64'(rom_addr), 64'(k + 2));
      if (k < 4) begin
        check("wrap_pc", 64'(out_pc_w), 64'(16'(16'hFFFE + 16'(k))));
        check("wrap_instr", 64'(out_instr_w), 64'(32'hA000_0000 + 32'(16'(16'hFFFE + 16'(k)))));
        check("wrap_addr", 64'(rom_addr_w), 64'(16'(16'hFFFE + 16'(k + 2))));
      end
      step(1'b1, 1'b0, 16'h0, 1'b0);
    end

    // Backpressure: head frozen, fetch at most two ahead.
    held_pc = out_pc; held_instr = out_instr;
    repeat (5) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_pc", 64'(out_pc), 64'(held_pc));
      check("bp_instr", 64'(out_instr), 64'(held_instr));
      check("bp_ahead", 64'(16'(rom_addr - out_pc)), 64'd2);
    end
    repeat (4) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      check("bp_resume_valid", 64'(out_valid), 64'd1);
    end

    // Redirect mid-stream.
    step(1'b1, 1'b1, 16'h0100, 1'b0);
    expect_stream(16'h0100, 32);
    check("redir_valid_c1", 64'(out_valid), 64'd0);
    check("redir_addr", 64'(rom_addr), 64'h0100);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check("redir_valid_c2", 64'(out_valid), 64'd0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check("redir_valid_c3", 64'(out_valid), 64'd1);
    check("redir_pc_c3", 64'(out_pc), 64'h0100);
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Redirect coinciding with a handshake on pc 5.
    step(1'b1, 1'b1, 16'h0003, 1'b0);
    expect_stream(16'h0003, 32);
    n = 0;
    while (!(out_valid && out_pc == 16'h0005) && n < 10) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      n++;
    end
    check("wait_pc5_valid", 64'(out_valid), 64'd1);
    check("wait_pc5", 64'(out_pc), 64'h0005);
    step(1'b1, 1'b1, 16'h0200, 1'b0);
    expect_stream(16'h0200, 32);
    n = 0;
    while (!out_valid && n < 6) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      n++;
    end
    check("redir_hs_valid", 64'(out_valid), 64'd1);
    check("redir_hs_next", 64'(out_pc), 64'h0200);
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Redirect while halted: pc loads, nothing issues until halt drops.
    step(1'b1, 1'b1, 16'h0300, 1'b1);
    expect_stream(16'h0300, 32);
    check("hredir_valid", 64'(out_valid), 64'd0);
    check("hredir_addr", 64'(rom_addr), 64'h0300);
    repeat (3) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("hredir_hold_valid", 64'(out_valid), 64'd0);
      check("hredir_hold_addr", 64'(rom_addr), 64'h0300);
    end
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check("hredir_resume_valid", 64'(out_valid), 64'd1);
    check("hredir_resume_pc", 64'(out_pc), 64'h0300);

    // Halt with one fetch in flight: it drains, then fetch stays frozen.
    frozen_addr = rom_addr;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    check("halt_drain_valid", 64'(out_valid), 64'd1);
    check("halt_drain_pc", 64'(out_pc), 64'h0301);
    check("halt_addr_c1", 64'(rom_addr), 64'(frozen_addr));
    repeat (3) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      check("halt_empty", 64'(out_valid), 64'd0);
      check("halt_addr", 64'(rom_addr), 64'(frozen_addr));
    end
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check("halt_resume_valid", 64'(out_valid), 64'd1);
    check("halt_resume_pc", 64'(out_pc), 64'(frozen_addr));

    // Asynchronous reset between clock edges.
    #2 sys_reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_pc", 64'(out_pc), 64'd0);
    check("arst_instr", 64'(out_instr), 64'd0);
    check("arst_addr", 64'(rom_addr), 64'h0000);
    check("arst_addr_wrap", 64'(rom_addr_w), 64'hFFFE);
    @(negedge sys_clock);
    sys_reset = 1'b0;
    exp_q.delete();
    expect_stream(16'h0000, 16);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_pc", 64'(out_pc), 64'h0000);
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
